switch_reader: RTL and testbench

Input-side front end for the board's slide switches. It sits between the raw switch pins and consumers such as the LED driver and the ALU operand registers. It synchronizes each asynchronous switch into the clock domain and debounces it with a per-bit stability counter. It presents a clean level vector and, optionally, a valid/ready change event carrying rise/fall masks.

---
 rtl/switch_reader_pkg.sv | 12 +
 rtl/switch_reader_if.sv | 25 ++
 rtl/switch_reader_debounce.sv | 45 ++++
 rtl/switch_reader.sv | 89 ++++++++
 tb/tb_switch_reader.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/switch_reader_pkg.sv
// Shared types and constants for the switch_reader front end.
package switch_reader_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } evt_state_t;

  localparam int SYNC_STAGES             = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/switch_reader_if.sv
// Change-event handshake between switch_reader (master) and its consumer (slave).
interface switch_reader_if #(
  parameter int WIDTH = 10
);

  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_rise;
  logic [WIDTH-1:0] evt_fall;

  modport master (
    output evt_valid,
    output evt_rise,
    output evt_fall,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_rise,
    input  evt_fall,
    output evt_ready
  );

endinterface

// File: rtl/switch_reader_debounce.sv
// sw_debounce_bit: one switch's synchronizer, stability counter and stable flop.
module sw_debounce_bit
  import switch_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CNT_W-1:0]       cnt;
  logic                   accept;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign accept = (sync != stable) && (cnt == CNT_LAST);
  assign rise   = accept & sync;
  assign fall   = accept & ~sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      // Clearing on acceptance keeps the counter from ever passing DEBOUNCE_CYCLES-1.
      if ((sync == stable) || accept) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      stable <= stable ^ accept;
    end
  end

endmodule

// File: rtl/switch_reader.sv
// Debounced slide-switch reader with optional change-event handshake.
// Event FSM and masks are built only when SWITCH_READER_EVENT_EN is defined.
module switch_reader
  import switch_reader_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     switches,
  output logic [WIDTH-1:0]     sw_stable,
  switch_reader_if.master      bus
);

  logic [WIDTH-1:0] rise_now;
  logic [WIDTH-1:0] fall_now;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin    (switches[i]),
      .stable (sw_stable[i]),
      .rise   (rise_now[i]),
      .fall   (fall_now[i])
    );
  end

`ifdef SWITCH_READER_EVENT_EN
  localparam logic [0:0] ST_IDLE    = IDLE;
  localparam logic [0:0] ST_PENDING = PENDING;

  logic [0:0]       state;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             change;

  assign change = |(rise_now | fall_now);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (change) begin
            rise_q <= rise_now;
            fall_q <= fall_now;
            state  <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          // A change landing on the accept edge starts the next event so nothing is dropped.
          if (bus.evt_ready) begin
            rise_q <= rise_now;
            fall_q <= fall_now;
            if (!change) state <= ST_IDLE;
          end else begin
            rise_q <= rise_q | rise_now;
            fall_q <= fall_q | fall_now;
          end
        end
        default: begin
          state  <= ST_IDLE;
          rise_q <= '0;
          fall_q <= '0;
        end
      endcase
    end
  end

  assign bus.evt_valid = (state == ST_PENDING);
  assign bus.evt_rise  = rise_q;
  assign bus.evt_fall  = fall_q;
`else
  logic unused_evt;

  assign unused_evt    = bus.evt_ready ^ (|rise_now) ^ (|fall_now);
  assign bus.evt_valid = 1'b0;
  assign bus.evt_rise  = '0;
  assign bus.evt_fall  = '0;
`endif

endmodule

// File: tb/tb_switch_reader.sv
// Directed bench for switch_reader with WIDTH=10, DEBOUNCE_CYCLES=4.
module tb_switch_reader;

`ifdef SWITCH_READER_EVENT_EN
  localparam logic EN = 1'b1;
`else
  localparam logic EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] switches = '0;
  logic [9:0] sw_stable;
  int         n_checks = 0;
  int         n_fail = 0;

  switch_reader_if #(.WIDTH(10)) bus ();

  switch_reader #(
    .WIDTH           (10),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .switches  (switches),
    .sw_stable (sw_stable),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    switches = '0;
    bus.evt_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    switches = 10'h3FF;
    bus.evt_ready = 1'b0;
    tick(3);
    n_checks++;
    if (sw_stable !== 10'h000) begin
      n_fail++; $display("FAIL reset_stable_in_reset: got %h want %h", sw_stable, 10'h000);
    end
    n_checks++;
    if (bus.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid_in_reset: got %b want 0", bus.evt_valid);
    end
    rst_n = 1'b1;
    tick(5);
    n_checks++;
    if (sw_stable !== 10'h000) begin
      n_fail++; $display("FAIL reset_stable_early: got %h want %h", sw_stable, 10'h000);
    end
    tick(1);
    n_checks++;
    if (sw_stable !== 10'h3FF) begin
      n_fail++; $display("FAIL reset_stable_edge6: got %h want %h", sw_stable, 10'h3FF);
    end
    n_checks++;
    if (bus.evt_valid !== EN) begin
      n_fail++; $display("FAIL reset_evt_valid: got %b want %b", bus.evt_valid, EN);
    end
    n_checks++;
    if (bus.evt_rise !== (EN ? 10'h3FF : 10'h000)) begin
      n_fail++; $display("FAIL reset_evt_rise: got %h want %h", bus.evt_rise, (EN ? 10'h3FF : 10'h000));
    end
    n_checks++;
    if (bus.evt_fall !== 10'h000) begin
      n_fail++; $display("FAIL reset_evt_fall: got %h want %h", bus.evt_fall, 10'h000);
    end
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
    n_checks++;
    if (bus.evt_valid !== 1'b0 || bus.evt_rise !== 10'h000) begin
      n_fail++; $display("FAIL reset_after_accept: valid %b rise %h want 0 000", bus.evt_valid, bus.evt_rise);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    switches = 10'h008;
    tick(3);
    switches = 10'h000;
    tick(2);
    switches = 10'h008;
    tick(5);
    n_checks++;
    if (sw_stable !== 10'h000 || bus.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL bounce_rejected: stable %h valid %b want 000 0", sw_stable, bus.evt_valid);
    end
    tick(1);
    n_checks++;
    if (sw_stable !== 10'h008) begin
      n_fail++; $display("FAIL bounce_stable: got %h want %h", sw_stable, 10'h008);
    end
    n_checks++;
    if (bus.evt_valid !== EN || bus.evt_rise !== (EN ? 10'h008 : 10'h000)) begin
      n_fail++; $display("FAIL bounce_event: valid %b rise %h want %b %h", bus.evt_valid, bus.evt_rise, EN, (EN ? 10'h008 : 10'h000));
    end
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
    tick(8);
    n_checks++;
    if (bus.evt_valid !== 1'b0 || sw_stable !== 10'h008) begin
      n_fail++; $display("FAIL bounce_single_event: valid %b stable %h want 0 008", bus.evt_valid, sw_stable);
    end
  endtask

  task automatic test_accumulate();
    do_reset();
    switches = 10'h001;
    tick(6);
    n_checks++;
    if (bus.evt_valid !== EN || bus.evt_rise !== (EN ? 10'h001 : 10'h000)) begin
      n_fail++; $display("FAIL accum_first: valid %b rise %h want %b %h", bus.evt_valid, bus.evt_rise, EN, (EN ? 10'h001 : 10'h000));
    end
    switches = 10'h000;
    tick(6);
    n_checks++;
    if (sw_stable !== 10'h000) begin
      n_fail++; $display("FAIL accum_stable: got %h want %h", sw_stable, 10'h000);
    end
    n_checks++;
    if (bus.evt_valid !== EN || bus.evt_rise !== (EN ? 10'h001 : 10'h000) ||
        bus.evt_fall !== (EN ? 10'h001 : 10'h000)) begin
      n_fail++; $display("FAIL accum_masks: valid %b rise %h fall %h want %b %h %h", bus.evt_valid, bus.evt_rise, bus.evt_fall, EN, (EN ? 10'h001 : 10'h000), (EN ? 10'h001 : 10'h000));
    end
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
    n_checks++;
    if (bus.evt_valid !== 1'b0 || bus.evt_fall !== 10'h000) begin
      n_fail++; $display("FAIL accum_accept: valid %b fall %h want 0 000", bus.evt_valid, bus.evt_fall);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    switches = 10'h001;
    tick(6);
    switches = 10'h021;
    tick(5);
    n_checks++;
    if (bus.evt_valid !== EN || bus.evt_rise !== (EN ? 10'h001 : 10'h000)) begin
      n_fail++; $display("FAIL b2b_held: valid %b rise %h want %b %h", bus.evt_valid, bus.evt_rise, EN, (EN ? 10'h001 : 10'h000));
    end
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
    n_checks++;
    if (sw_stable !== 10'h021) begin
      n_fail++; $display("FAIL b2b_stable: got %h want %h", sw_stable, 10'h021);
    end
    n_checks++;
    if (bus.evt_valid !== EN || bus.evt_rise !== (EN ? 10'h020 : 10'h000) || bus.evt_fall !== 10'h000) begin
      n_fail++; $display("FAIL b2b_new_event: valid %b rise %h fall %h want %b %h 000", bus.evt_valid, bus.evt_rise, bus.evt_fall, EN, (EN ? 10'h020 : 10'h000));
    end
    bus.evt_ready = 1'b1;
    tick(1);
    bus.evt_ready = 1'b0;
    n_checks++;
    if (bus.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drain: got %b want 0", bus.evt_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    switches = 10'h080;
    tick(4);
    rst_n = 1'b0;
    tick(1);
    n_checks++;
    if (sw_stable !== 10'h000 || bus.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_in_reset: stable %h valid %b want 000 0", sw_stable, bus.evt_valid);
    end
    rst_n = 1'b1;
    tick(5);
    n_checks++;
    if (sw_stable !== 10'h000 || bus.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_counter_cleared: stable %h valid %b want 000 0", sw_stable, bus.evt_valid);
    end
    tick(1);
    n_checks++;
    if (sw_stable !== 10'h080) begin
      n_fail++; $display("FAIL mid_redebounce: got %h want %h", sw_stable, 10'h080);
    end
  endtask

  initial begin
    bus.evt_ready = 1'b0;
    test_reset();
    test_bounce();
    test_accumulate();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
